// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - turn/hazard/brake tail-light sequencer with step prescaler
module taillight_seq #(
  parameter int LIGHTS = 3,
  parameter int DIV    = 1,
  localparam int SW    = $clog2(LIGHTS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l,
  input  logic              r,
  input  logic              brake,
  output logic [LIGHTS-1:0] led_l,
  output logic [LIGHTS-1:0] led_r,
  output logic [2:0]        state,
  output logic [SW-1:0]     step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(LIGHTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEFT    = 3'd1,
    S_RIGHT   = 3'd2,
    S_HAZ_ON  = 3'd3,
    S_HAZ_OFF = 3'd4
  } state_t;

  state_t            r_state;
  logic [SW-1:0]     r_step;
  logic [CW-1:0]     r_cnt;
  logic              w_tick;
  logic [LIGHTS-1:0] w_therm;
  logic [LIGHTS-1:0] w_brake_fill;

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            if (l && r) begin
              r_state <= S_HAZ_ON;
            end else if (l) begin
              r_state <= S_LEFT;
              r_step  <= SW'(1);
            end else if (r) begin
              r_state <= S_RIGHT;
              r_step  <= SW'(1);
            end
          end
        end
        // A started turn sequence always runs out; requests are ignored until IDLE.
        S_LEFT, S_RIGHT: begin
          if (w_tick) begin
            if (r_step >= STEP_MAX) begin
              r_state <= S_IDLE;
              r_step  <= '0;
            end else begin
              r_step <= r_step + SW'(1);
            end
          end
        end
        S_HAZ_ON: begin
          if (w_tick) r_state <= S_HAZ_OFF;
        end
        S_HAZ_OFF: begin
          if (w_tick) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < LIGHTS; i++) begin
      w_therm[i] = (i < int'(r_step));
    end
  end

  assign w_brake_fill = brake ? '1 : '0;

  // Brake lights every side that is not actively sequencing; hazard owns both sides.
  always_comb begin
    led_l = w_brake_fill;
    led_r = w_brake_fill;
    case (r_state)
      S_LEFT:    led_l = w_therm;
      S_RIGHT:   led_r = w_therm;
      S_HAZ_ON: begin
        led_l = '1;
        led_r = '1;
      end
      S_HAZ_OFF: begin
        led_l = '0;
        led_r = '0;
      end
      default: ;
    endcase
  end

  assign state = r_state;
  assign step  = r_step;

endmodule

// File: tb/tb_taillight_seq.sv
// tb/tb_taillight_seq.sv - self-checking bench for taillight_seq (3x/DIV1 and 5x/DIV4)
module tb_taillight_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic l = 1'b0;
  logic r = 1'b0;
  logic brake = 1'b0;

  logic [2:0] st0, st1;
  logic [1:0] sp0;
  logic [2:0] sp1;
  logic [2:0] ll0, lr0;
  logic [4:0] ll1, lr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  taillight_seq #(.LIGHTS(3), .DIV(1)) dut3 (
    .clk(clk), .reset(reset), .l(l), .r(r), .brake(brake),
    .led_l(ll0), .led_r(lr0), .state(st0), .step(sp0)
  );

  taillight_seq #(.LIGHTS(5), .DIV(4)) dut5 (
    .clk(clk), .reset(reset), .l(l), .r(r), .brake(brake),
    .led_l(ll1), .led_r(lr1), .state(st1), .step(sp1)
  );

  logic [39:0] obs [2];
  assign obs[0] = {st0, 5'(sp0), 16'(ll0), 16'(lr0)};
  assign obs[1] = {st1, 5'(sp1), 16'(ll1), 16'(lr1)};

  function automatic int nl(int k);
    return (k == 0) ? 3 : 5;
  endfunction

  function automatic int nd(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard on, 4 hazard off
  int m_cnt [2];
  int m_mode [2];
  int m_step [2];
  bit m_tick;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_mode[k] = 0;
        m_step[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_tick = (m_cnt[k] == nd(k) - 1);
        m_cnt[k] = m_tick ? 0 : m_cnt[k] + 1;
        if (m_tick) begin
          if (m_mode[k] == 0) begin
            if (l && r) m_mode[k] = 3;
            else if (l) begin m_mode[k] = 1; m_step[k] = 1; end
            else if (r) begin m_mode[k] = 2; m_step[k] = 1; end
          end else if (m_mode[k] == 1 || m_mode[k] == 2) begin
            if (m_step[k] == nl(k)) begin m_mode[k] = 0; m_step[k] = 0; end
            else m_step[k] = m_step[k] + 1;
          end else if (m_mode[k] == 3) begin
            m_mode[k] = 4;
          end else begin
            m_mode[k] = 0;
          end
        end
      end
    end
  end

  function automatic logic [39:0] exp_vec(int k);
    logic [15:0] all1, th, el, er;
    all1 = 16'((1 << nl(k)) - 1);
    th   = 16'((1 << m_step[k]) - 1);
    el   = brake ? all1 : 16'h0;
    er   = brake ? all1 : 16'h0;
    case (m_mode[k])
      1: el = th;
      2: er = th;
      3: begin el = all1; er = all1; end
      4: begin el = 16'h0; er = 16'h0; end
      default: ;
    endcase
    return {3'(m_mode[k]), 5'(m_step[k]), el, er};
  endfunction

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 brake = i[0];
      #1;
      checks++;
      if (st0 !== 3'd0 || sp0 !== 2'd0 || ll0 !== (brake ? 3'b111 : 3'b000) || lr0 !== (brake ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL reset_dut3 got st=%0d sp=%0d l=%b r=%b brake=%b", st0, sp0, ll0, lr0, brake);
      end
      checks++;
      if (st1 !== 3'd0 || sp1 !== 3'd0 || ll1 !== (brake ? 5'h1f : 5'h0)) begin
        errors++;
        $display("FAIL reset_dut5 got st=%0d sp=%0d l=%b exp st=0 sp=0", st1, sp1, ll1);
      end
    end
  endtask

  task automatic test_left_held();
    logic [2:0] exp_l [6];
    exp_l = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011};
    brake = 1'b0;
    l = 1'b1;
    r = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if (ll0 !== exp_l[i] || lr0 !== 3'b000 || st0 !== ((i == 3) ? 3'd0 : 3'd1)) begin
        errors++;
        $display("FAIL left_held cyc=%0d got st=%0d l=%b r=%b exp l=%b r=000", i, st0, ll0, lr0, exp_l[i]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL left_held_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
        end
      end
    end
    l = 1'b0;
  endtask

  task automatic test_right_pulse();
    logic [2:0] exp_r [6];
    exp_r = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    l = 1'b0;
    r = 1'b1;
    brake = 1'b0;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 r = 1'b0;
      #1;
      checks++;
      if (lr0 !== exp_r[i] || ll0 !== 3'b000) begin
        errors++;
        $display("FAIL right_pulse cyc=%0d got l=%b r=%b exp l=000 r=%b", i, ll0, lr0, exp_r[i]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL right_pulse_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_hazard();
    logic [2:0] exp_st [3];
    exp_st = '{3'd3, 3'd4, 3'd0};
    l = 1'b1;
    r = 1'b1;
    brake = 1'b0;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if (st0 !== exp_st[i % 3] || ll0 !== ((i % 3 == 0) ? 3'b111 : 3'b000) || lr0 !== ll0) begin
        errors++;
        $display("FAIL hazard cyc=%0d got st=%0d l=%b r=%b exp st=%0d", i, st0, ll0, lr0, exp_st[i % 3]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL hazard_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
        end
      end
    end
    l = 1'b0;
    r = 1'b0;
  endtask

  task automatic test_brake();
    l = 1'b1;
    r = 1'b0;
    brake = 1'b0;
    pulse_reset();
    @(posedge clk);
    #1 l = 1'b0;
    @(posedge clk);
    #1 brake = 1'b1;
    #1;
    checks++;
    if (ll0 !== 3'b011 || lr0 !== 3'b111) begin
      errors++;
      $display("FAIL brake_left got l=%b r=%b exp l=011 r=111", ll0, lr0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 begin brake = 1'b0; l = 1'b1; r = 1'b1; end
    @(posedge clk);
    #1 begin l = 1'b0; r = 1'b0; end
    @(posedge clk);
    #1 brake = 1'b1;
    #1;
    checks++;
    if (st0 !== 3'd4 || ll0 !== 3'b000 || lr0 !== 3'b000) begin
      errors++;
      $display("FAIL brake_haz_off got st=%0d l=%b r=%b exp st=4 l=000 r=000", st0, ll0, lr0);
    end
    @(posedge clk);
    #2;
    checks++;
    if (st0 !== 3'd0 || ll0 !== 3'b111 || lr0 !== 3'b111) begin
      errors++;
      $display("FAIL brake_idle got st=%0d l=%b r=%b exp st=0 l=111 r=111", st0, ll0, lr0);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL brake_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
      end
    end
    brake = 1'b0;
  endtask

  task automatic test_prescaler();
    int es;
    l = 1'b1;
    r = 1'b0;
    brake = 1'b0;
    pulse_reset();
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1 r = (n >= 10 && n < 20);
      #1;
      es = (n < 4) ? 0 : ((n / 4) % 6);
      checks++;
      if (int'(sp1) !== es || ll1 !== 5'((1 << es) - 1) || lr1 !== 5'h0) begin
        errors++;
        $display("FAIL prescaler n=%0d got sp=%0d l=%b r=%b exp sp=%0d", n, sp1, ll1, lr1, es);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL prescaler_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
        end
      end
    end
    l = 1'b0;
    r = 1'b0;
  endtask

  task automatic test_async_reset();
    l = 1'b1;
    r = 1'b0;
    brake = 1'b0;
    pulse_reset();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (st0 !== 3'd0 || sp0 !== 2'd0 || ll0 !== 3'b000 || lr0 !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got st=%0d sp=%0d l=%b r=%b exp 0/0/000/000", st0, sp0, ll0, lr0);
    end
    brake = 1'b1;
    #1;
    checks++;
    if (ll0 !== 3'b111 || lr0 !== 3'b111 || ll1 !== 5'h1f || lr1 !== 5'h1f) begin
      errors++;
      $display("FAIL async_reset_brake got l3=%b r3=%b l5=%b r5=%b exp all ones", ll0, lr0, ll1, lr1);
    end
    brake = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #2;
      checks++;
      if (int'(sp1) !== ((n >= 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL prescaler_restart n=%0d got sp=%0d exp %0d", n, sp1, (n >= 4) ? 1 : 0);
      end
    end
    l = 1'b0;
  endtask

  task automatic test_random();
    bit rst_pulse;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      brake = ($urandom_range(0, 3) == 0);
      rst_pulse = ($urandom_range(0, 39) == 0);
      if (rst_pulse) reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random_model cyc=%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
      reset = 1'b1;
    end
    l = 1'b0;
    r = 1'b0;
    brake = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_held();
    test_right_pulse();
    test_hazard();
    test_brake();
    test_prescaler();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/taillight_seq.md
Name: taillight_seq

Overview:
Parametrised turn/hazard/brake tail-light sequencer; next generation of the team's 3-light left/right taillight FSM. Generalises lights per side, adds a step-rate prescaler and a brake override, and exposes an explicit state/step code. Sits between debounced driver switch inputs and the LED driver pins.

Parameters:
LIGHTS, 3, lamps per side (1..16); index 0 = innermost lamp
DIV, 1, clock cycles per sequencer step (>=1); 1 = step every clock
SW, $clog2(LIGHTS+1), derived width of step output (localparam, not overridable)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
l  input  1  left turn request, level
r  input  1  right turn request, level; l&r together = hazard request
brake  input  1  brake pedal, level, combinational override
led_l  output  LIGHTS  left lamps, 1 = on
led_r  output  LIGHTS  right lamps, 1 = on
state  output  3  current state code: IDLE=0, LEFT=1, RIGHT=2, HAZ_ON=3, HAZ_OFF=4
step  output  SW  current sequence step (0 outside LEFT/RIGHT)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, step=0, prescaler cnt=0; led_l/led_r = all-ones if brake=1 else 0. Reset mid-sequence aborts immediately; no completion.
- Prescaler: cnt counts 0..DIV-1, wraps to 0; tick = (cnt==DIV-1). DIV=1 -> tick every cycle. State/step update only on clk edges with tick=1; l/r/brake sampled for transitions only then.
- Transitions (on tick):
  - IDLE: l&r -> HAZ_ON; l only -> LEFT, step=1; r only -> RIGHT, step=1; none -> IDLE.
  - LEFT/RIGHT: step<LIGHTS -> step+1; step==LIGHTS -> IDLE, step=0. Sequence always runs to completion; l/r changes (including l&r) ignored until back in IDLE.
  - HAZ_ON -> HAZ_OFF unconditionally; HAZ_OFF -> IDLE unconditionally (re-evaluates request next tick).
  - Held request repeats: e.g. l held with LIGHTS=3 gives steps 1,2,3, then 1 tick IDLE (all off), then 1,2,3 ...
  - Undefined codes 5..7 -> IDLE, step=0 next clock (regardless of tick).
- Outputs (Moore on state/step, plus combinational brake):
  - LEFT: led_l[i]=1 for i<step (thermometer, inner-outward); led_r=0.
  - RIGHT: mirror on led_r; led_l=0.
  - HAZ_ON: both all-ones; HAZ_OFF and IDLE: both 0.
  - brake=1: every side not currently sequencing (not the active side in LEFT/RIGHT) forced all-ones. In HAZ_ON/HAZ_OFF brake has no effect (both sides sequencing). Brake never alters state/step.
- No latency beyond one clock from a tick edge to new state; brake->led is same-cycle combinational.
- LIGHTS=1: LEFT lasts one tick then IDLE.

Test Plan:
- LIGHTS=3, DIV=1: reset=0 for 4 cycles, release with l=1 -> state 1, led_l=001,011,111 on successive clocks, then IDLE led_l=000, then 001 again while l held; led_r=000 throughout.
- LIGHTS=3, DIV=1: r pulse for 1 clock only -> full RIGHT sequence 001,011,111 completes, then IDLE and stays.
- LIGHTS=3: l=r=1 held -> state alternates 3,4,0,3,4,0...; leds 111/111, 000/000, 000/000 repeating.
- LIGHTS=3: during LEFT step 2 assert brake -> led_l=011, led_r=111 same cycle; in HAZ_OFF with brake=1 -> both 000; in IDLE with brake=1 -> both 111.
- LIGHTS=5, DIV=4: l held -> each step persists exactly 4 clocks; led_l reaches 11111 at step 5, IDLE after 24 clocks of sequence; r asserted mid-sequence ignored.
- Async reset pulse (reset=0 between clock edges) at LEFT step 2 -> state=0, step=0, led_l=000 immediately without a clock edge; prescaler restarts at 0.
